// File: rtl/gpio_edge_irq_if.sv
// CPU register bus for gpio_edge_irq: 8-bit address/data, one-cycle read and write strobes.
// Read data is registered in the peripheral and valid one cycle after rd_en.
interface gpio_edge_irq_if;
  logic [7:0] addr;
  logic [7:0] din;
  logic [7:0] dout;
  logic       wr_en;
  logic       rd_en;

  modport master (output addr, output din, output wr_en, output rd_en, input dout);
  modport slave  (input addr, input din, input wr_en, input rd_en, output dout);
endinterface

// File: rtl/gpio_edge_irq.sv
// GPIO pin conditioning (sync, debounce, edge detect) with latched per-pin flags and a level irq.
// GPIO_IRQ_DEBOUNCE_EN builds the per-pin debounce counters; otherwise deb follows s2 directly.
module gpio_edge_irq #(
  parameter int ADDR_LSB          = 0,
  parameter int OPT_MEM_ADDR_BITS = 1,
  parameter int DEBOUNCE_CYCLES   = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  gpio_edge_irq_if.slave   bus,
  input  logic [7:0]       pins,
  output logic             irq
);

  localparam logic [OPT_MEM_ADDR_BITS:0] A_PIN   = (OPT_MEM_ADDR_BITS+1)'(0);
  localparam logic [OPT_MEM_ADDR_BITS:0] A_IE    = (OPT_MEM_ADDR_BITS+1)'(1);
  localparam logic [OPT_MEM_ADDR_BITS:0] A_EDGE  = (OPT_MEM_ADDR_BITS+1)'(2);
  localparam logic [OPT_MEM_ADDR_BITS:0] A_IFLAG = (OPT_MEM_ADDR_BITS+1)'(3);

  logic [OPT_MEM_ADDR_BITS:0] loc_addr;
  logic [7:0] s1, s2, deb, deb_nxt;
  logic [7:0] ie, edge_sel, iflag, iflag_nxt;
  logic [7:0] set_flag, rd_mux;
  logic       unused_addr;

  assign loc_addr    = bus.addr[ADDR_LSB+OPT_MEM_ADDR_BITS:ADDR_LSB];
  assign unused_addr = ^bus.addr;

`ifdef GPIO_IRQ_DEBOUNCE_EN
  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [CW-1:0] cnt     [8];
  logic [CW-1:0] cnt_nxt [8];

  // A pin is accepted only after s2 disagrees with deb for DEBOUNCE_CYCLES edges in a row.
  always_comb begin
    deb_nxt = deb;
    cnt_nxt = cnt;
    for (int i = 0; i < 8; i++) begin
      if (s2[i] == deb[i]) begin
        cnt_nxt[i] = '0;
      end else if (cnt[i] == CNT_MAX) begin
        deb_nxt[i] = s2[i];
        cnt_nxt[i] = '0;
      end else begin
        cnt_nxt[i] = cnt[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 8; i++) begin
      if (!reset_n) cnt[i] <= '0;
      else          cnt[i] <= cnt_nxt[i];
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg = (DEBOUNCE_CYCLES > 0);
  assign deb_nxt    = s2;
`endif

  // A flag sets on the edge deb changes, when the new level equals the selected edge polarity.
  assign set_flag = (deb ^ deb_nxt) & ~(deb_nxt ^ edge_sel);

  always_comb begin
    iflag_nxt = iflag | set_flag;
    if (bus.wr_en && loc_addr == A_IFLAG) iflag_nxt = (iflag & ~bus.din) | set_flag;
  end

  always_comb begin
    rd_mux = 8'h00;
    case (loc_addr)
      A_PIN:   rd_mux = deb;
      A_IE:    rd_mux = ie;
      A_EDGE:  rd_mux = edge_sel;
      A_IFLAG: rd_mux = iflag;
      default: rd_mux = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1       <= 8'h00;
      s2       <= 8'h00;
      deb      <= 8'h00;
      ie       <= 8'h00;
      edge_sel <= 8'h00;
      iflag    <= 8'h00;
      bus.dout <= 8'h00;
      irq      <= 1'b0;
    end else begin
      s1    <= pins;
      s2    <= s1;
      deb   <= deb_nxt;
      iflag <= iflag_nxt;
      irq   <= |(iflag & ie);
      if (bus.wr_en) begin
        if (loc_addr == A_IE)   ie       <= bus.din;
        if (loc_addr == A_EDGE) edge_sel <= bus.din;
      end else if (bus.rd_en) begin
        bus.dout <= rd_mux;
      end
    end
  end

endmodule
